note_key_scheduler: RTL
=======================

Name: note_key_scheduler

Overview:
- Sits between the DE2 push-buttons and the single-note tone generator. It decides which note code drives the generator's 4-bit note input.
- Synchronises and debounces NUM_KEYS raw buttons and applies last-note priority.
- Enforces a minimum note duration and a short silence gap between different notes, so changes are clean and audible.
- Output `note` connects directly to the tone generator's note input.

Parameters:
- NUM_KEYS, 4, number of buttons. Key i maps to note code i (0=A, 1=B, 2=C, 3=D). Must be ≤15.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key change (10 ms at 50 MHz).
- MIN_NOTE_CYCLES, 2500000, minimum cycles a note is held once started (50 ms).
- GAP_CYCLES, 250000, silence cycles inserted between two different notes (5 ms).

Ports:
- clk  in  1  50 MHz system clock.
- resetn  in  1  synchronous, active-low reset.
- key_n  in  NUM_KEYS  raw buttons, active-low, asynchronous to clk.
- note  out  4  note code to the tone generator; 4'hF = silence.
- active_key  out  NUM_KEYS  one-hot key currently sounding; 0 when silent.
- note_change  out  1  one-cycle pulse in the cycle after `note` changes value.

Behaviour:
- Single clock domain; every register is updated on posedge clk. Reset is synchronous, active-low.
- Reset values:
  - note = 4'hF, active_key = 0, note_change = 0.
  - FSM in IDLE; all debounced key states = released.
  - All counters = 0; pending target = none.
- Input conditioning, per key:
  - 2-FF synchroniser, then debounce counter.
  - The counter increments while the synced value differs from the stable value, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable value flips and the counter clears.
  - Press event = one-cycle pulse on stable released→pressed. Release event = the reverse.
- Press latency: raw key held low from cycle N gives `note` updated by the end of cycle N+DEBOUNCE_CYCLES+3.
- Multiple press events in one cycle: the lowest index wins.
- FSM IDLE:
  - note = F.
  - On a press event: go to PLAY with current = winning key, and load the timer with MIN_NOTE_CYCLES-1.
- FSM PLAY:
  - note = current index; the timer decrements to 0 and saturates there.
  - Pending target updates every cycle, with later events overriding earlier ones:
    - press event on a key other than current → pending = that key;
    - release of current with other keys held → pending = lowest held key;
    - release of current with no keys held → pending = none;
    - re-press of current → pending = current.
  - When timer == 0 and pending ≠ current: go to GAP and load the timer with GAP_CYCLES-1.
  - Changes requested before the timer expires are deferred, never dropped.
- FSM GAP:
  - note = F; the timer counts down. When it reaches 0:
    - pending still held → PLAY(pending);
    - else any key held → PLAY(lowest held);
    - else → IDLE.
  - Entering PLAY always reloads MIN_NOTE_CYCLES-1.
- Holding a key never retriggers the note. Releasing and re-pressing the same key within the minimum window causes no gap.
- `active_key` is one-hot of current in PLAY and 0 in IDLE and GAP.
- Reset asserted mid-operation: all outputs return to reset values on the next clk edge.
- Reset deasserted while a key is held: the key is treated as a new press after debounce.

Decomposition:
- Package note_pkg holds:
  - NOTE_A = 4'd0, NOTE_B = 4'd1, NOTE_C = 4'd2, NOTE_D = 4'd3, NOTE_SILENCE = 4'hF;
  - FSM state encoding IDLE / PLAY / GAP.
- Sub-module key_debouncer, one instance per key via generate.
  - Ports: clk, resetn, key_n, pressed, press_pulse, release_pulse.
  - Contains the synchroniser and debounce counter.

Test Plan (DEBOUNCE_CYCLES=4, MIN_NOTE_CYCLES=10, GAP_CYCLES=2):
- Reset: resetn=0 for 5 cycles with key_n[0]=0 → note=F, active_key=0 during reset. After release, note=0 within 7 cycles and note_change pulses once.
- Bounce rejection: key_n[1] toggles every 2 cycles for 20 cycles → note stays F. Then held low from cycle N → note=1 exactly at N+7.
- Minimum duration: key0 plays and is released 3 cycles later → note remains 0 for 10 cycles total, then F. active_key returns to 0.
- Last-note priority: hold key0, press key2 → after the timer expires, F for 2 cycles, then 2. Release key2 → F for 2 cycles after the min window, then 0.
- Simultaneous press in IDLE: key1 and key3 press on the same cycle → note=1 and no gap follows. Release key1 → after gap, note=3.
- Reset mid-note: resetn=0 during PLAY → next cycle note=F, active_key=0, FSM in IDLE, pending cleared.

Source files
------------

// File: rtl/note_pkg.sv
// Shared note codes, FSM state encoding and the key-to-note mapping
// for the push-button note scheduler.
package note_pkg;

    localparam logic [3:0] NOTE_A       = 4'd0;
    localparam logic [3:0] NOTE_B       = 4'd1;
    localparam logic [3:0] NOTE_C       = 4'd2;
    localparam logic [3:0] NOTE_D       = 4'd3;
    localparam logic [3:0] NOTE_SILENCE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Key index to tone-generator note code; keys beyond D map straight through.
    function automatic logic [3:0] key_to_note(input logic [3:0] k);
        case (k)
            4'd0:    return NOTE_A;
            4'd1:    return NOTE_B;
            4'd2:    return NOTE_C;
            4'd3:    return NOTE_D;
            default: return k;
        endcase
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button: two-flop synchroniser followed by a stability counter.
// Emits the debounced level plus one-cycle press/release pulses that are
// registered together with the level flip.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    // Synchroniser; resets to "released" so a key held through reset is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

    // Count consecutive cycles the synced level disagrees with the accepted level; flip on the last one.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt           <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (~sync_p1 == pressed) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt           <= '0;
                pressed       <= ~sync_p1;
                press_pulse   <= ~sync_p1;
                release_pulse <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_key_scheduler.sv
// Chooses the note driven into the single-note tone generator from the
// debounced push-buttons: last-note priority, a guaranteed minimum note
// length, and a short silence between two different notes.
module note_key_scheduler
    import note_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MIN_NOTE_CYCLES = 2500000,
    parameter int GAP_CYCLES      = 250000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [3:0]          note,
    output logic [NUM_KEYS-1:0] active_key,
    output logic                note_change
);

    localparam int            TMAX     = (MIN_NOTE_CYCLES > GAP_CYCLES) ? MIN_NOTE_CYCLES : GAP_CYCLES;
    localparam int            TW       = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] MIN_LOAD = TW'(MIN_NOTE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;

    state_t        state;
    logic [3:0]    cur;
    logic          pend_vld;
    logic [3:0]    pend_key;
    logic [TW-1:0] timer;

    logic [NUM_KEYS-1:0] press_other;
    logic                pend_nxt_vld;
    logic [3:0]          pend_nxt_key;
    logic                keep_cur;
    logic                gap_go;
    logic [3:0]          gap_key;

    // Lowest set index; 0 when the vector is empty (callers guard with |v).
    function automatic logic [3:0] lowest(input logic [NUM_KEYS-1:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic [NUM_KEYS-1:0] onehot(input logic [3:0] k);
        logic [NUM_KEYS-1:0] r;
        for (int i = 0; i < NUM_KEYS; i++) begin
            r[i] = (k == 4'(i));
        end
        return r;
    endfunction

    function automatic logic bit_at(input logic [NUM_KEYS-1:0] v, input logic [3:0] k);
        return |(v & onehot(k));
    endfunction

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk          (clk),
            .resetn       (resetn),
            .key_n        (key_n[i]),
            .pressed      (pressed[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i])
        );
    end

    // Pending target including this cycle's events (later rules override earlier ones), and the
    // note to resume after a gap.
    always_comb begin
        press_other  = press_pulse & ~onehot(cur);
        pend_nxt_vld = pend_vld;
        pend_nxt_key = pend_key;
        if (|press_other) begin
            pend_nxt_vld = 1'b1;
            pend_nxt_key = lowest(press_other);
        end
        if (bit_at(release_pulse, cur)) begin
            if (|pressed) begin
                pend_nxt_vld = 1'b1;
                pend_nxt_key = lowest(pressed);
            end else begin
                pend_nxt_vld = 1'b0;
            end
        end
        if (bit_at(press_pulse, cur)) begin
            pend_nxt_vld = 1'b1;
            pend_nxt_key = cur;
        end
        keep_cur = pend_nxt_vld && (pend_nxt_key == cur);

        gap_go  = 1'b0;
        gap_key = 4'd0;
        if (pend_vld && bit_at(pressed, pend_key)) begin
            gap_go  = 1'b1;
            gap_key = pend_key;
        end else if (|pressed) begin
            gap_go  = 1'b1;
            gap_key = lowest(pressed);
        end
    end

    // Scheduler FSM with registered note, active_key and note_change outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            cur         <= 4'd0;
            pend_vld    <= 1'b0;
            pend_key    <= 4'd0;
            timer       <= '0;
            note        <= NOTE_SILENCE;
            active_key  <= '0;
            note_change <= 1'b0;
        end else begin
            note_change <= 1'b0;
            case (state)
                IDLE: begin
                    if (|press_pulse) begin
                        state       <= PLAY;
                        cur         <= lowest(press_pulse);
                        pend_vld    <= 1'b1;
                        pend_key    <= lowest(press_pulse);
                        timer       <= MIN_LOAD;
                        note        <= key_to_note(lowest(press_pulse));
                        active_key  <= onehot(lowest(press_pulse));
                        note_change <= 1'b1;
                    end
                end
                PLAY: begin
                    pend_vld <= pend_nxt_vld;
                    pend_key <= pend_nxt_key;
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (!keep_cur) begin
                        state       <= GAP;
                        timer       <= GAP_LOAD;
                        note        <= NOTE_SILENCE;
                        active_key  <= '0;
                        note_change <= 1'b1;
                    end
                end
                GAP: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (gap_go) begin
                        state       <= PLAY;
                        cur         <= gap_key;
                        pend_vld    <= 1'b1;
                        pend_key    <= gap_key;
                        timer       <= MIN_LOAD;
                        note        <= key_to_note(gap_key);
                        active_key  <= onehot(gap_key);
                        note_change <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        pend_vld <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pend_vld   <= 1'b0;
                    note       <= NOTE_SILENCE;
                    active_key <= '0;
                end
            endcase
        end
    end

endmodule
